// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) feeding the HI/LO writeback path.
// One quotient bit per cycle; result_o = {remainder, quotient}.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_ZERO = 2'd1,
        ON       = 2'd2,
        END      = 2'd3
    } state_t;

    // Conditional two's-complement negation, also used to take magnitudes.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t               state_r, state_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH-1:0]     rem_r, dvd_r, dsr_r;
    logic                 sign_q_r, sign_r_r;
    logic [2*WIDTH-1:0]   result_r;
    logic                 ready_r;

    logic [WIDTH:0]       trial_s;
    logic [WIDTH-1:0]     rem_nxt_s, dvd_nxt_s;
    logic                 last_s, go_s;

    assign go_s   = start_i & ~annul_i;
    assign last_s = (cnt_r == CNT_W'(WIDTH - 1));

    // One restoring step: shifted partial remainder minus divisor decides the quotient bit.
    always_comb begin
        trial_s   = {rem_r, dvd_r[WIDTH-1]} - {1'b0, dsr_r};
        rem_nxt_s = {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
        dvd_nxt_s = {dvd_r[WIDTH-2:0], 1'b0};
        if (!trial_s[WIDTH]) begin
            rem_nxt_s = trial_s[WIDTH-1:0];
            dvd_nxt_s = {dvd_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt_s = {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
            dvd_nxt_s = {dvd_r[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (go_s) begin
                    if (opdata2_i == {WIDTH{1'b0}}) begin
                        state_nxt_s = DIV_ZERO;
                    end else begin
                        state_nxt_s = ON;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DIV_ZERO: state_nxt_s = END;
            ON: begin
                if (annul_i) begin
                    state_nxt_s = IDLE;
                end else if (last_s) begin
                    state_nxt_s = END;
                end else begin
                    state_nxt_s = ON;
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = END;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch, iteration datapath and registered result/ready.
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            dvd_r    <= {WIDTH{1'b0}};
            dsr_r    <= {WIDTH{1'b0}};
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            result_r <= {(2*WIDTH){1'b0}};
            ready_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    if (go_s && (opdata2_i != {WIDTH{1'b0}})) begin
                        dvd_r    <= neg_if(opdata1_i, signed_i & opdata1_i[WIDTH-1]);
                        dsr_r    <= neg_if(opdata2_i, signed_i & opdata2_i[WIDTH-1]);
                        sign_q_r <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        sign_r_r <= signed_i & opdata1_i[WIDTH-1];
                        rem_r    <= {WIDTH{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                DIV_ZERO: begin
                    result_r <= {(2*WIDTH){1'b0}};
                    ready_r  <= 1'b1;
                end
                ON: begin
                    if (!annul_i) begin
                        rem_r <= rem_nxt_s;
                        dvd_r <= dvd_nxt_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (last_s) begin
                            result_r <= {neg_if(rem_nxt_s, sign_r_r), neg_if(dvd_nxt_s, sign_q_r)};
                            ready_r  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        ready_r <= 1'b0;
                    end
                end
                default: ready_r <= 1'b0;
            endcase
        end
    end

    assign result_o = result_r;
    assign ready_o  = ready_r;
    // Hold request is combinational so EX stalls in the same cycle it raises start.
    assign stall_o  = start_i & ~annul_i & (state_r != END);

endmodule
